serializer_gen2: RTL and testbench

SERIALIZER_GEN2 -- requirements
Module: serializer_gen2

---
 rtl/serializer_gen2.sv | 92 +++++++++
 tb/tb_serializer_gen2.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_gen2.sv
// serializer_gen2: word-to-serial transmitter with data, PRBS7, 1010 and zero sources.
// Define SERIALIZER_PRBS_EN to build the PRBS7 generator; otherwise mode 01 sends zeros.
module serializer_gen2 #(
    parameter int                   WORDWIDTH = 8,
    parameter logic [WORDWIDTH-1:0] IDLEWORD  = WORDWIDTH'(8'hBC)
) (
    input  logic                 bitCK,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic                 msbFirst,
    input  logic [WORDWIDTH-1:0] din,
    input  logic                 dinValid,
    output logic                 wordCK,
    output logic                 load,
    output logic                 sout,
    output logic [7:0]           missCount
);

    localparam int                   CW      = $clog2(WORDWIDTH);
    localparam logic [CW-1:0]        LAST    = CW'(WORDWIDTH - 1);
    localparam logic [WORDWIDTH-1:0] ALTWORD = {(WORDWIDTH / 2){2'b01}};

    logic [CW-1:0]        cnt;
    logic [WORDWIDTH-1:0] sreg;
    logic [WORDWIDTH-1:0] srcWord;
    logic                 msbL;

    assign wordCK = cnt[CW-1];
    assign load   = (cnt == LAST) && !reset;
    assign sout   = msbL ? sreg[WORDWIDTH-1] : sreg[0];

`ifdef SERIALIZER_PRBS_EN
    logic [6:0]           prbs;
    logic [6:0]           prbsNext;
    logic [WORDWIDTH-1:0] prbsWord;

    // Unroll one word's worth of LFSR steps; bit k is the k-th new bit.
    always_comb begin
        logic [6:0] s;
        s        = prbs;
        prbsWord = '0;
        for (int k = 0; k < WORDWIDTH; k++) begin
            prbsWord[k] = s[6] ^ s[5];
            s           = {s[5:0], prbsWord[k]};
        end
        prbsNext = s;
    end

    always_ff @(posedge bitCK) begin
        if (reset) begin
            prbs <= 7'h7F;
        end else if (load && mode == 2'b01) begin
            prbs <= prbsNext;
        end
    end
`endif

    always_comb begin
        srcWord = '0;
        case (mode)
            2'b00:   srcWord = dinValid ? din : IDLEWORD;
`ifdef SERIALIZER_PRBS_EN
            2'b01:   srcWord = prbsWord;
`endif
            2'b10:   srcWord = ALTWORD;
            default: srcWord = '0;
        endcase
    end

    always_ff @(posedge bitCK) begin
        if (reset) begin
            cnt       <= '0;
            sreg      <= '0;
            msbL      <= 1'b0;
            missCount <= 8'd0;
        end else begin
            cnt <= cnt + CW'(1);
            if (load) begin
                sreg <= srcWord;
                msbL <= msbFirst;
                if (mode == 2'b00 && !dinValid && missCount != 8'hFF) begin
                    missCount <= missCount + 8'd1;
                end
            end else if (enable) begin
                sreg <= msbL ? {sreg[WORDWIDTH-2:0], 1'b0}
                             : {1'b0, sreg[WORDWIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_serializer_gen2.sv
// tb_serializer_gen2: directed literal checks plus randomized run against a
// word/bit-position model of the serializer.
module tb_serializer_gen2;

    localparam int W = 8;

`ifdef SERIALIZER_PRBS_EN
    localparam bit PRBS_ON = 1'b1;
`else
    localparam bit PRBS_ON = 1'b0;
`endif

    logic         bitCK    = 1'b0;
    logic         reset    = 1'b1;
    logic         enable   = 1'b1;
    logic [1:0]   mode     = 2'd0;
    logic         msbFirst = 1'b0;
    logic [W-1:0] din      = '0;
    logic         dinValid = 1'b0;
    logic         wordCK;
    logic         load;
    logic         sout;
    logic [7:0]   missCount;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    serializer_gen2 #(.WORDWIDTH(W)) dut (
        .bitCK    (bitCK),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .msbFirst (msbFirst),
        .din      (din),
        .dinValid (dinValid),
        .wordCK   (wordCK),
        .load     (load),
        .sout     (sout),
        .missCount(missCount)
    );

    always #5 bitCK = ~bitCK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: reference PRBS7 table, bit-position pointer into the current word.
    bit seq [127];
    bit m_bits [W];
    int m_cnt  = 0;
    int m_pos  = W;
    int m_miss = 0;
    int m_ptr  = 0;

    initial begin
        bit [6:0] s;
        s = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            seq[i] = s[6] ^ s[5];
            s      = {s[5:0], seq[i]};
        end
    end

    always @(posedge bitCK) begin
        bit [W-1:0] w;
        if (reset) begin
            m_cnt  = 0;
            m_pos  = W;
            m_miss = 0;
            m_ptr  = 0;
        end else begin
            if (m_cnt == W - 1) begin
                w = '0;
                case (mode)
                    2'd0: w = dinValid ? din : 8'hBC;
                    2'd1: if (PRBS_ON) begin
                        for (int k = 0; k < W; k++) w[k] = seq[(m_ptr + k) % 127];
                        m_ptr = (m_ptr + W) % 127;
                    end
                    2'd2: for (int k = 0; k < W; k++) w[k] = (k % 2 == 0);
                    default: w = '0;
                endcase
                for (int i = 0; i < W; i++) m_bits[i] = msbFirst ? w[W-1-i] : w[i];
                m_pos = 0;
                if (mode == 2'd0 && !dinValid && m_miss < 255) m_miss++;
            end else if (enable && m_pos < W) begin
                m_pos++;
            end
            m_cnt = (m_cnt + 1) % W;
        end
    end

    function automatic logic exp_sout();
        return (m_pos < W) ? m_bits[m_pos] : 1'b0;
    endfunction

    always @(negedge bitCK) begin
        if (chk_en) begin
            chk("m_sout", 32'(sout), 32'(exp_sout()));
            chk("m_load", 32'(load), 32'((m_cnt == W - 1) && !reset));
            chk("m_wordCK", 32'(wordCK), 32'(m_cnt >= W / 2));
            chk("m_miss", 32'(missCount), 32'(m_miss));
        end
    end

    task automatic tick();
        @(posedge bitCK);
        #2;
    endtask

    task automatic wait_load();
        int n = 0;
        while (load !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_load", 32'(load), 1);
    endtask

    logic [7:0]  got;
    logic [13:0] got14;

    initial begin
        reset = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_sout", 32'(sout), 0);
        chk("rst_load", 32'(load), 0);
        chk("rst_wordCK", 32'(wordCK), 0);
        chk("rst_miss", 32'(missCount), 0);

        // A5, LSB first
        mode = 2'd0; din = 8'hA5; dinValid = 1'b1; msbFirst = 1'b0;
        enable = 1'b1; reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) chk("pre_load", 32'(load), 0);
        end
        chk("first_load", 32'(load), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            got[i] = sout;
        end
        chk("lsb_A5", 32'(got), 32'hA5);

        // 81, MSB first, msbFirst toggled mid-word
        chk("load_2", 32'(load), 1);
        msbFirst = 1'b1; din = 8'h81;
        for (int i = 0; i < 8; i++) begin
            tick();
            got[i] = sout;
            if (i == 3) msbFirst = 1'b0;
        end
        chk("msb_81", 32'(got), 32'h81);

        // idle words and missCount saturation
        dinValid = 1'b0;
        repeat (300 * W) tick();
        chk("miss_sat", 32'(missCount), 255);
        wait_load();
        for (int i = 0; i < 8; i++) begin
            tick();
            got[i] = sout;
        end
        chk("idle_BC", 32'(got), 32'hBC);
        chk("miss_hold", 32'(missCount), 255);

        // enable low for 3 edges mid-word
        din = 8'h02; dinValid = 1'b1;
        tick();
        chk("en_b0", 32'(sout), 0);
        tick();
        chk("en_b1", 32'(sout), 1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_hold", 32'(sout), 1);
        end
        enable = 1'b1;
        tick();
        chk("en_resume", 32'(sout), 0);
        tick();
        tick();
        chk("en_load", 32'(load), 1);
        din = 8'h01;
        tick();
        chk("en_newword", 32'(sout), 1);

        // reset at counter 5 for 2 edges
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("mr_sout", 32'(sout), 0);
        chk("mr_load", 32'(load), 0);
        chk("mr_wordCK", 32'(wordCK), 0);
        chk("mr_miss", 32'(missCount), 0);
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) chk("mr_pre_load", 32'(load), 0);
        end
        chk("mr_load7", 32'(load), 1);

        // PRBS7 sequence start
        reset = 1'b1;
        tick();
        tick();
        mode = 2'd1; msbFirst = 1'b0; reset = 1'b0;
        repeat (7) tick();
        chk("prbs_load", 32'(load), 1);
        for (int i = 0; i < 14; i++) begin
            tick();
            got14[i] = sout;
        end
`ifdef SERIALIZER_PRBS_EN
        chk("prbs_14", 32'(got14), 32'h3040);
`else
        chk("prbs_off", 32'(got14), 0);
`endif
        repeat (300) tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            mode     = 2'($urandom_range(0, 3));
            msbFirst = 1'($urandom_range(0, 1));
            din      = W'($urandom);
            dinValid = ($urandom_range(0, 9) < 7);
            enable   = ($urandom_range(0, 9) < 8);
            reset    = ($urandom_range(0, 199) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
